// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch requester.
// Optional performance counters in fetch_requester are enabled with FETCH_PERF_EN.
package fetch_pkg;

    // Byte address fetched first after reset.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Issue-to-data latency of the instruction BRAM read port.
    localparam int DEFAULT_MEM_LATENCY = 2;

    // Response buffer entries (power of two, at least latency + 2).
    localparam int DEFAULT_BUF_DEPTH = 4;

    // One stage of the in-flight tracking pipe: a read that has been issued
    // but whose data has not yet appeared on the BRAM read bus.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } inflight_t;

    // One returned instruction word tagged with the address it came from.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

    // 32-bit add that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetch_entry_t holding returned instruction words until
// decode consumes them. Supports push and pop in the same cycle (count is
// unchanged) and a flush that empties it and overrides any push/pop.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_BUF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  cnt;
    logic           full;
    logic           do_pop;

    assign full   = (cnt == CW'(DEPTH));
    assign empty  = (cnt == '0);
    assign do_pop = pop && !empty;
    assign head   = mem[rd_ptr];
    assign count  = cnt;

    // Pointer and occupancy bookkeeping; flush and reset both empty the buffer.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Entry storage; contents need no reset because the count gates validity.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // The requester only issues reads it has room for, so a push into a full
    // buffer without a matching pop means the credit accounting is broken.
    always_ff @(posedge clk) begin
        if (rst_n && !flush) begin
            assert (!(push && !do_pop && full));
        end
    end

endmodule

// File: rtl/fetch_requester.sv
// Instruction-fetch initiator for a fixed-latency instruction BRAM.
// Generates sequential word addresses, issues one read per cycle while buffer
// credit remains, tracks reads in flight, captures returned words into a
// small FIFO for decode, and squashes everything on a redirect.
// Define FETCH_PERF_EN to add the perf_stall_cycles / perf_squashed counters.
//
// Decode handshake: instr/instr_pc are meaningful only while instr_valid is
// high. The word is consumed at the rising edge ending a cycle in which
// instr_valid=1 and hazard=0; while hazard=1 the same word stays presented
// unchanged. A redirect in the same cycle discards the presented word instead.
module fetch_requester
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          MEM_LATENCY = DEFAULT_MEM_LATENCY,
    parameter int          BUF_DEPTH   = DEFAULT_BUF_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_read_en,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        hazard,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_squashed
`endif
);

    localparam int            CW      = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW:0]   CREDITS = (CW + 1)'(BUF_DEPTH);

    // Configuration sanity: the buffer must absorb a full pipe of responses
    // plus the word being presented, and pointer wrap needs a power of two.
    if (MEM_LATENCY < 1) begin : g_latency_chk
        $error("MEM_LATENCY must be at least 1");
    end
    if (BUF_DEPTH < MEM_LATENCY + 2) begin : g_depth_chk
        $error("BUF_DEPTH must be at least MEM_LATENCY + 2");
    end
    if ((BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_pow2_chk
        $error("BUF_DEPTH must be a power of two");
    end

    logic [31:0]    pc;
    inflight_t      pipe [MEM_LATENCY];
    logic [CW-1:0]  inflight_count;
    logic [CW-1:0]  fifo_count;
    logic [CW:0]    outstanding;
    logic           issue;
    logic           push;
    logic           pop;
    logic           fifo_empty;
    fetch_entry_t   push_entry;
    fetch_entry_t   head;

    // Count reads still travelling through the BRAM latency pipe.
    always_comb begin
        inflight_count = '0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            inflight_count = inflight_count + CW'(pipe[i].valid);
        end
    end

    // Issue, capture and consume decisions. A redirect blocks all three so
    // nothing from the old stream can slip past the flush.
    always_comb begin
        outstanding = {1'b0, fifo_count} + {1'b0, inflight_count};
        issue       = rst_n && !redirect_valid && (outstanding < CREDITS);
        push        = pipe[MEM_LATENCY-1].valid && !redirect_valid;
        instr_valid = !fifo_empty;
        pop         = instr_valid && !hazard && !redirect_valid;
        push_entry  = '{instr: mem_rdata, pc: pipe[MEM_LATENCY-1].pc};
        mem_read_en = issue;
        mem_addr    = pc;
        instr       = instr_valid ? head.instr : 32'd0;
        instr_pc    = instr_valid ? head.pc    : 32'd0;
    end

    // Fetch address: restart on reset, jump on redirect, advance one word per issue.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= word_align(redirect_pc);
        end else if (issue) begin
            pc <= pc + 32'd4;
        end
    end

    // In-flight pipe: stage 0 records this cycle's issue, the last stage lines
    // up with the cycle its data is on mem_rdata. Redirect squashes every stage.
    always_ff @(posedge clk) begin
        if (!rst_n || redirect_valid) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= '{valid: issue, pc: pc};
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] squash_now;

    // Everything outstanding at a redirect (in the pipe or buffered) is discarded.
    assign squash_now = 32'(outstanding);

    // Saturating stall and squash counters, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_stall_cycles <= '0;
            perf_squashed     <= '0;
        end else begin
            if (instr_valid && hazard) begin
                perf_stall_cycles <= sat_add(perf_stall_cycles, 32'd1);
            end
            if (redirect_valid) begin
                perf_squashed <= sat_add(perf_squashed, squash_now);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_requester.sv
// Directed bench for fetch_requester against a 2-cycle BRAM model whose word
// at index i reads as 32'hA000_0000 + i.
module tb_fetch_requester;

    logic        clk;
    logic        rst_n;
    logic        mem_read_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        hazard;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_squashed;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Clock and bounded run time.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    fetch_requester dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_read_en    (mem_read_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .hazard         (hazard),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_squashed     (perf_squashed)
`endif
    );

    // BRAM model: data for a read issued in cycle t is on mem_rdata in t+2.
    logic        v1 = 1'b0;
    logic        v2 = 1'b0;
    logic [31:0] a1 = 32'd0;
    logic [31:0] a2 = 32'd0;
    always @(posedge clk) begin
        v1 <= mem_read_en;
        a1 <= mem_addr;
        v2 <= v1;
        a2 <= a1;
    end
    assign mem_rdata = v2 ? (32'hA000_0000 + ((a2 >> 2) & 32'h0000_07FF)) : 32'd0;

    // Driver tasks.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic h, input logic rv, input logic [31:0] rpc);
        next_cycle();
        hazard         = h;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_instr(input string tag, input logic [31:0] exp_instr, input logic [31:0] exp_pc);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, "_instr"}, instr, exp_instr);
        chk({tag, "_pc"}, instr_pc, exp_pc);
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    endtask

    task automatic chk_rd(input string tag, input logic exp_en);
        chk({tag, "_rd"}, {31'd0, mem_read_en}, {31'd0, exp_en});
    endtask

    // Directed sequence; comments give the cycle index after reset release.
    initial begin
        rst_n          = 1'b0;
        hazard         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk_rd("rst", 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk_empty("rst");
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);

        // Cycle 0: first issue straight out of reset.
        next_cycle();
        rst_n = 1'b1;
        #2;
        chk_rd("c0", 1'b1);
        chk("c0_addr", mem_addr, 32'h0);
        chk_empty("c0");
        cyc(0, 0, 0);                                  // 1
        chk("c1_addr", mem_addr, 32'h4);
        chk_rd("c1", 1'b1);
        cyc(0, 0, 0);                                  // 2
        chk_empty("c2");
        cyc(0, 0, 0);                                  // 3
        chk_instr("c3", 32'hA000_0000, 32'h0);
        cyc(0, 0, 0);                                  // 4
        chk_instr("c4", 32'hA000_0001, 32'h4);

        // Cycles 5..14: decode stalls on the word at pc 8.
        cyc(1, 0, 0);                                  // 5
        chk_instr("c5", 32'hA000_0002, 32'h8);
        chk_rd("c5", 1'b1);
        chk("c5_addr", mem_addr, 32'h14);
        for (int i = 6; i <= 14; i++) begin
            cyc(1, 0, 0);
            chk_instr("hold", 32'hA000_0002, 32'h8);
            chk_rd("hold", 1'b0);
        end
        cyc(0, 0, 0);                                  // 15: pop, no credit yet
        chk_instr("c15", 32'hA000_0002, 32'h8);
        chk_rd("c15", 1'b0);
        cyc(0, 0, 0);                                  // 16
        chk_instr("c16", 32'hA000_0003, 32'hC);
        chk_rd("c16", 1'b1);
        chk("c16_addr", mem_addr, 32'h18);
        for (int k = 4; k <= 8; k++) begin             // 17..21
            cyc(0, 0, 0);
            chk_instr("resume", 32'hA000_0000 + 32'(k), 32'(4 * k));
        end

        // Cycle 22: redirect to an unaligned address mid-stream.
        cyc(0, 1, 32'h0000_0103);
        chk_rd("c22", 1'b0);
        chk_instr("c22", 32'hA000_0009, 32'h24);
        cyc(0, 0, 0);                                  // 23
        chk_empty("c23");
        chk("c23_instr", instr, 32'h0);
        chk("c23_addr", mem_addr, 32'h100);
        chk_rd("c23", 1'b1);
        cyc(0, 0, 0);                                  // 24
        chk_empty("c24");
        cyc(0, 0, 0);                                  // 25
        chk_empty("c25");
        cyc(0, 0, 0);                                  // 26
        chk_instr("c26", 32'hA000_0040, 32'h100);
        cyc(0, 0, 0);                                  // 27
        chk_instr("c27", 32'hA000_0041, 32'h104);

        // Cycle 28: redirect together with hazard.
        cyc(1, 1, 32'h0000_0200);
        chk_instr("c28", 32'hA000_0042, 32'h108);
        chk_rd("c28", 1'b0);
        cyc(0, 0, 0);                                  // 29
        chk_empty("c29");
        chk("c29_addr", mem_addr, 32'h200);
        cyc(0, 0, 0);                                  // 30
        chk_empty("c30");
        cyc(0, 0, 0);                                  // 31
        chk_empty("c31");
        cyc(0, 0, 0);                                  // 32
        chk_instr("c32", 32'hA000_0080, 32'h200);

        // Cycles 33/34: redirect during pop and push, then a second redirect.
        cyc(0, 1, 32'h0000_0040);
        chk_instr("c33", 32'hA000_0081, 32'h204);
        cyc(0, 1, 32'h0000_0080);                      // 34
        chk_empty("c34");
        chk("c34_addr", mem_addr, 32'h40);
        chk_rd("c34", 1'b0);
        cyc(0, 0, 0);                                  // 35
        chk_empty("c35");
        chk("c35_addr", mem_addr, 32'h80);
        chk_rd("c35", 1'b1);
        cyc(0, 0, 0);                                  // 36
        chk_empty("c36");
        cyc(0, 0, 0);                                  // 37
        chk_empty("c37");
        cyc(0, 0, 0);                                  // 38
        chk_instr("c38", 32'hA000_0020, 32'h80);
        cyc(0, 0, 0);                                  // 39
        chk_instr("c39", 32'hA000_0021, 32'h84);

        // Cycle 40: one-cycle reset with two reads in flight.
        next_cycle();
        rst_n = 1'b0;
        #2;
        chk_rd("c40", 1'b0);
        next_cycle();                                  // 41
        rst_n = 1'b1;
        #2;
        chk_empty("c41");
        chk("c41_instr", instr, 32'h0);
        chk("c41_pc", instr_pc, 32'h0);
        chk("c41_addr", mem_addr, 32'h0);
        chk_rd("c41", 1'b1);
        cyc(0, 0, 0);                                  // 42
        chk_empty("c42");
        cyc(0, 0, 0);                                  // 43
        chk_empty("c43");
        cyc(0, 0, 0);                                  // 44
        chk_instr("c44", 32'hA000_0000, 32'h0);
        cyc(0, 0, 0);                                  // 45
        chk_instr("c45", 32'hA000_0001, 32'h4);

        // Cycle 46: redirect near the top of the address space to cover wrap.
        cyc(0, 1, 32'hFFFF_FFF8);
        cyc(0, 0, 0);                                  // 47
        chk("c47_addr", mem_addr, 32'hFFFF_FFF8);
        cyc(0, 0, 0);                                  // 48
        chk("c48_addr", mem_addr, 32'hFFFF_FFFC);
        cyc(0, 0, 0);                                  // 49
        chk("c49_addr", mem_addr, 32'h0);
        chk_empty("c49");
        cyc(0, 0, 0);                                  // 50
        chk_instr("c50", 32'hA000_07FE, 32'hFFFF_FFF8);
        cyc(0, 0, 0);                                  // 51
        chk_instr("c51", 32'hA000_07FF, 32'hFFFF_FFFC);
        cyc(0, 0, 0);                                  // 52
        chk_instr("c52", 32'hA000_0000, 32'h0);

        // Cycles 53..64: fresh reset, 5 stall cycles, redirect with 3 outstanding.
        next_cycle();
        rst_n = 1'b0;
        #2;
        next_cycle();                                  // 54
        rst_n = 1'b1;
        #2;
`ifdef FETCH_PERF_EN
        chk("c54_stall", perf_stall_cycles, 32'd0);
        chk("c54_squash", perf_squashed, 32'd0);
`endif
        cyc(0, 0, 0);                                  // 55
        cyc(0, 0, 0);                                  // 56
        cyc(1, 0, 0);                                  // 57
        chk_instr("c57", 32'hA000_0000, 32'h0);
        for (int i = 58; i <= 61; i++) begin
            cyc(1, 0, 0);
            chk_instr("stall", 32'hA000_0000, 32'h0);
        end
        cyc(0, 0, 0);                                  // 62
        chk_instr("c62", 32'hA000_0000, 32'h0);
        chk_rd("c62", 1'b0);
        cyc(0, 1, 32'h0);                              // 63
        chk_instr("c63", 32'hA000_0001, 32'h4);
        cyc(0, 0, 0);                                  // 64
        chk_empty("c64");
`ifdef FETCH_PERF_EN
        chk("c64_stall", perf_stall_cycles, 32'd5);
        chk("c64_squash", perf_squashed, 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
